alu_req_arbiter: RTL and testbench

//   Shares one 8-bit ALU (3-bit opcode, f/ovf/take_branch outputs) between NUM_REQ requesters.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_req_arbiter_alu.sv | 38 +++
 rtl/alu_req_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: operand width, opcodes and the FSM state type.
package alu_pkg;

    localparam int unsigned ALU_W = 8;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_NOT = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRA = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_BEQ = 3'b110;
    localparam logic [2:0] ALU_BNE = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

endpackage

// File: rtl/alu_req_arbiter_alu.sv
// Shared 8-bit ALU: purely combinational, fed from the arbiter's latched operand registers.
module alu_req_arbiter_alu
    import alu_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] f,
    output logic             ovf,
    output logic             take_branch
);

    logic [ALU_W-1:0] sum;

    assign sum = a + b;

    always_comb begin
        f           = '0;
        ovf         = 1'b0;
        take_branch = 1'b0;
        unique case (op)
            ALU_ADD: begin
                f   = sum;
                // Signed overflow: like-signed operands producing a result of the other sign.
                ovf = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
            end
            ALU_NOT: f = ~b;
            ALU_AND: f = a & b;
            ALU_OR:  f = a | b;
            ALU_SRA: f = {a[ALU_W-1], a[ALU_W-1:1]};
            ALU_SHL: f = {a[ALU_W-2:0], 1'b0};
            ALU_BEQ: take_branch = (a == b);
            ALU_BNE: take_branch = (a != b);
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ valid/ready requesters, with a
// registered backpressured response channel and saturating per-requester op counters.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*3-1:0]     req_op,
    input  logic [NUM_REQ*8-1:0]     req_a,
    input  logic [NUM_REQ*8-1:0]     req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [ALU_W-1:0]         rsp_f,
    output logic                     rsp_ovf,
    output logic                     rsp_branch,
    input  logic                     cnt_clr,
    output logic [NUM_REQ*CNT_W-1:0] op_count
);

    state_e state_q, state_d;

    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  winner;
    logic             any_valid;
    logic             accept;
    logic             rsp_done;

    logic [2:0]       op_q;
    logic [ALU_W-1:0] a_q, b_q;
    logic [ID_W-1:0]  id_q;

    logic [ALU_W-1:0] alu_f;
    logic             alu_ovf;
    logic             alu_branch;

    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    // First valid requester strictly after ptr, wrapping; the smallest offset wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        int              idx;
        pick = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (valid[idx]) pick = ID_W'(idx);
        end
        return pick;
    endfunction

    assign any_valid = |req_valid;
    assign winner    = rr_pick(req_valid, rr_ptr_q);
    assign accept    = (state_q == IDLE) && any_valid && !rst;
    assign rsp_done  = (state_q == RESP) && rsp_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: grant is combinational and only offered in IDLE.
    always_comb begin
        req_ready = '0;
        if (accept) req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_f      <= '0;
            rsp_ovf    <= 1'b0;
            rsp_branch <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= req_op[int'(winner)*3 +: 3];
                a_q      <= req_a[int'(winner)*8 +: 8];
                b_q      <= req_b[int'(winner)*8 +: 8];
                id_q     <= winner;
                rr_ptr_q <= winner;
            end
            if (state_q == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= id_q;
                rsp_f      <= alu_f;
                rsp_ovf    <= alu_ovf;
                rsp_branch <= alu_branch;
            end
            if (rsp_done) rsp_valid <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst || cnt_clr) begin
                cnt_q[i] <= '0;
            end else if (rsp_done && (int'(rsp_id) == i) && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
        assign op_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    alu_req_arbiter_alu u_alu (
        .op          (op_q),
        .a           (a_q),
        .b           (b_q),
        .f           (alu_f),
        .ovf         (alu_ovf),
        .take_branch (alu_branch)
    );

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed self-checking bench for alu_req_arbiter; a second instance with CNT_W=2 covers saturation.
module tb_alu_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [5:0]  req_op;
    logic [15:0] req_a, req_b;
    logic        rsp_ready;
    logic        cnt_clr;

    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [7:0]  rsp_f;
    logic        rsp_ovf, rsp_branch;
    logic [31:0] op_count;

    logic [1:0]  req_ready2;
    logic        rsp_valid2;
    logic [0:0]  rsp_id2;
    logic [7:0]  rsp_f2;
    logic        rsp_ovf2, rsp_branch2;
    logic [3:0]  op_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_req_arbiter #(.NUM_REQ(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_f(rsp_f), .rsp_ovf(rsp_ovf),
        .rsp_branch(rsp_branch), .cnt_clr(cnt_clr), .op_count(op_count)
    );

    alu_req_arbiter #(.NUM_REQ(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid2),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id2), .rsp_f(rsp_f2), .rsp_ovf(rsp_ovf2),
        .rsp_branch(rsp_branch2), .cnt_clr(cnt_clr), .op_count(op_count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b);
        req_op[i*3 +: 3] = op;
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        cnt_clr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; cnt_clr = 1'b0; rsp_ready = 1'b1;
        req_op = '0; req_a = '0; req_b = '0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %h exp 0", rsp_valid); end
        checks++; if ({rsp_id, rsp_f, rsp_ovf, rsp_branch} !== 11'h0) begin errors++; $display("FAIL reset_rsp_fields got %h exp 0", {rsp_id, rsp_f, rsp_ovf, rsp_branch}); end
        checks++; if (op_count !== 32'h0) begin errors++; $display("FAIL reset_op_count got %h exp 0", op_count); end
        checks++; if (op_count2 !== 4'h0) begin errors++; $display("FAIL reset_op_count2 got %h exp 0", op_count2); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    endtask

    task automatic test_single_op();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 3'b000, 8'h4E, 8'h65);
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
        step();
        req_valid = 2'b00;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %h exp 0", rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %h exp 1", rsp_valid); end
        checks++; if (rsp_f !== 8'hB3) begin errors++; $display("FAIL single_f got %h exp b3", rsp_f); end
        checks++; if (rsp_ovf !== 1'b1) begin errors++; $display("FAIL single_ovf got %h exp 1", rsp_ovf); end
        checks++; if (rsp_branch !== 1'b0) begin errors++; $display("FAIL single_branch got %h exp 0", rsp_branch); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id got %h exp 0", rsp_id); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %h exp 0", rsp_valid); end
        checks++; if (op_count[15:0] !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", op_count[15:0]); end
    endtask

    task automatic test_contention();
        int         exp_id;
        logic [7:0] exp_f;
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 3'b000, 8'h01, 8'h02);
        set_req(1, 3'b011, 8'h0F, 8'hF0);
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_id = g % 2;
            exp_f  = (exp_id == 1) ? 8'hFF : 8'h03;
            #1;
            checks++; if (req_ready !== 2'(1 << exp_id)) begin errors++; $display("FAIL contention_grant%0d got %b exp %b", g, req_ready, 2'(1 << exp_id)); end
            step(); step();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(exp_id)) begin errors++; $display("FAIL contention_rsp%0d got valid=%h id=%h exp valid=1 id=%0d", g, rsp_valid, rsp_id, exp_id); end
            checks++; if (rsp_f !== exp_f) begin errors++; $display("FAIL contention_f%0d got %h exp %h", g, rsp_f, exp_f); end
            step();
            checks++; if (op_count[exp_id*16 +: 16] !== 16'(g / 2 + 1)) begin errors++; $display("FAIL contention_count%0d got %0d exp %0d", g, op_count[exp_id*16 +: 16], g / 2 + 1); end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(0, 3'b110, 8'h86, 8'h86);
        set_req(1, 3'b000, 8'h11, 8'h22);
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        #1;
        step();
        req_valid = 2'b10;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++; if ({rsp_valid, rsp_branch, rsp_f, rsp_id} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin errors++; $display("FAIL bp_hold%0d got valid=%h br=%h f=%h id=%h exp 1 1 00 0", i, rsp_valid, rsp_branch, rsp_f, rsp_id); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b exp 00", i, req_ready); end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_branch !== 1'b1) begin errors++; $display("FAIL bp_pre_hs got valid=%h br=%h exp 1 1", rsp_valid, rsp_branch); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_after_hs_valid got %h exp 0", rsp_valid); end
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_idle_ready got %b exp 10", req_ready); end
        checks++; if (op_count[15:0] !== 16'd1 || op_count[31:16] !== 16'd0) begin errors++; $display("FAIL bp_count got %h exp 00000001", op_count); end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_in_exec();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 3'b000, 8'h01, 8'h01);
        set_req(1, 3'b000, 8'h02, 8'h02);
        req_valid = 2'b01;
        #1;
        step();
        req_valid = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_valid%0d got %h exp 0", i, rsp_valid); end
            checks++; if (op_count !== 32'h0) begin errors++; $display("FAIL rst_exec_count%0d got %h exp 0", i, op_count); end
            step();
        end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_exec_grant got %b exp 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_saturation();
        do_reset();
        rsp_ready = 1'b1;
        set_req(1, 3'b010, 8'hF0, 8'h3C);
        req_valid = 2'b10;
        for (int k = 1; k <= 4; k++) begin
            #1;
            step(); step(); step();
            checks++; if (op_count2[3:2] !== 2'((k > 3) ? 3 : k)) begin errors++; $display("FAIL sat_count2_%0d got %0d exp %0d", k, op_count2[3:2], (k > 3) ? 3 : k); end
            checks++; if (op_count[31:16] !== 16'(k)) begin errors++; $display("FAIL sat_count16_%0d got %0d exp %0d", k, op_count[31:16], k); end
        end
        step(); step();
        checks++; if (rsp_valid !== 1'b1 || rsp_f !== 8'h30) begin errors++; $display("FAIL sat_rsp got valid=%h f=%h exp 1 30", rsp_valid, rsp_f); end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        req_valid = 2'b00;
        checks++; if (op_count2 !== 4'h0) begin errors++; $display("FAIL clr_count2 got %h exp 0", op_count2); end
        checks++; if (op_count !== 32'h0) begin errors++; $display("FAIL clr_count16 got %h exp 0", op_count); end
    endtask

    task automatic test_op_sweep();
        logic [7:0] exp_f  [7] = '{8'hA5, 8'h00, 8'hFF, 8'hD2, 8'h4A, 8'h00, 8'h00};
        logic       exp_br [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_req(0, 3'(i + 1), 8'hA5, 8'h5A);
            req_valid = 2'b01;
            #1;
            step();
            req_valid = 2'b00;
            step();
            checks++; if (rsp_f !== exp_f[i]) begin errors++; $display("FAIL sweep_f_op%0d got %h exp %h", i + 1, rsp_f, exp_f[i]); end
            checks++; if (rsp_branch !== exp_br[i] || rsp_ovf !== 1'b0) begin errors++; $display("FAIL sweep_flags_op%0d got br=%h ovf=%h exp br=%h ovf=0", i + 1, rsp_branch, rsp_ovf, exp_br[i]); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_reset_in_exec();
        test_saturation();
        test_op_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
